// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared types and constants for the PWM capture block.
//   pwm_cap_state_t   : capture FSM state encoding
//   PWM_DEFAULT_WIDTH : default counter/output width
package pwm_pkg;

  localparam int PWM_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_edge_detect.sv
// pwm_edge_detect -- produces the sampled PWM level and its rising-edge strobe.
// Build option: PWM_CAPTURE_SYNC_EN inserts a two-flop synchronizer ahead of
// the edge detector (adds two cycles of latency); otherwise pwm_in is used
// directly and must already be synchronous to clk.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   pwm_in : PWM line under measurement
//   level  : sampled level s
//   rise   : s & ~prev, combinational
module pwm_edge_detect
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise
);

`ifdef PWM_CAPTURE_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

  assign level = sync2;
`else
  assign level = pwm_in;
`endif

  logic prev;

  // prev resets high so a line that is already high at reset release is
  // not mistaken for a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high time of a PWM signal in clk cycles.
// Build option: PWM_CAPTURE_SYNC_EN (see pwm_edge_detect) synchronizes pwm_in.
// Ports:
//   clk       : clock
//   reset     : asynchronous active-high reset
//   enable    : capture enable, low returns the FSM to IDLE
//   pwm_in    : PWM line under measurement
//   clear_ovf : synchronous clear of the sticky overflow flag
//   period    : last measured period
//   duty      : last measured high-cycle count
//   valid     : one-cycle strobe when period/duty update
//   overflow  : sticky, set when a period exceeds 2^WIDTH-1 cycles
//
// state   | meaning
// IDLE    | waiting for an enabled rising edge to start a period
// MEASURE | counting the current period; each rise closes it and starts the next
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty,
  output logic             valid,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic level;
  logic rise;

  pwm_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise)
  );

  pwm_cap_state_t   state, state_nxt;
  logic [WIDTH-1:0] cnt_period, cnt_period_nxt;
  logic [WIDTH-1:0] cnt_high, cnt_high_nxt;
  logic             capture;
  logic             ovf_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt_period <= '0;
      cnt_high   <= '0;
    end else begin
      state      <= state_nxt;
      cnt_period <= cnt_period_nxt;
      cnt_high   <= cnt_high_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_period_nxt = cnt_period;
    cnt_high_nxt   = cnt_high;
    capture        = 1'b0;
    ovf_set        = 1'b0;
    case (state)
      IDLE: begin
        if (enable && rise) begin
          state_nxt      = MEASURE;
          cnt_period_nxt = CNT_ONE;
          cnt_high_nxt   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          // counters hold; the partial period is dropped on the next rise
          state_nxt = IDLE;
        end else if (rise) begin
          capture        = 1'b1;
          cnt_period_nxt = CNT_ONE;
          cnt_high_nxt   = CNT_ONE;
        end else if (cnt_period == CNT_MAX) begin
          // no edge within the counter range: stuck-high or stuck-low line
          ovf_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_period_nxt = cnt_period + CNT_ONE;
          if (level && (cnt_high != CNT_MAX))
            cnt_high_nxt = cnt_high + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period   <= '0;
      duty     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        period <= cnt_period;
        duty   <= cnt_high;
      end
      // a new overflow event takes priority over a coincident clear
      overflow <= ovf_set | (overflow & ~clear_ovf);
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- directed bench for pwm_capture (WIDTH=8).
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int W = 8;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_in;
  logic         clear_ovf;
  logic [W-1:0] period;
  logic [W-1:0] duty;
  logic         valid;
  logic         overflow;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .clear_ovf (clear_ovf),
    .period    (period),
    .duty      (duty),
    .valid     (valid),
    .overflow  (overflow)
  );

  typedef struct {
    int cyc;
    int per;
    int dty;
  } cap_t;

  typedef struct {
    int per;        // stimulus period
    int dty;        // stimulus high cycles
    int nper;       // full periods driven before the closing rise
    int exp_count;  // expected number of valid pulses
    int exp_per;
    int exp_duty;
  } vec_t;

  cap_t caps[$];
  vec_t vecs[5];
  int   cyc;
  int   ovf_cyc;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's pwm level, then sample just after the edge.
  task automatic step(input logic p);
    pwm_in = p;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) caps.push_back('{cyc, int'(period), int'(duty)});
    if (overflow && ovf_cyc < 0) ovf_cyc = cyc;
  endtask

  task automatic pwm_period(input int p, input int d);
    for (int i = 0; i < p; i++) step(i < d);
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset(input logic p);
    reset     = 1'b1;
    pwm_in    = p;
    enable    = 1'b1;
    clear_ovf = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b0;
    cyc     = 0;
    ovf_cyc = -1;
    caps.delete();
  endtask

  task automatic check_caps(input string name, input int first, input int exp_per[$],
                            input int exp_dty[$]);
    check({name, "_count"}, caps.size(), exp_per.size());
    for (int j = 0; j < caps.size() && j < exp_per.size(); j++) begin
      check($sformatf("%s_per%0d", name, j), caps[j].per, exp_per[j]);
      check($sformatf("%s_duty%0d", name, j), caps[j].dty, exp_dty[j]);
    end
    // valid lands P cycles after each rise that opened the measured period
    if (caps.size() > 0) check({name, "_first_cyc"}, caps[0].cyc, first);
  endtask

  initial begin
    int first;
    int c;
    int ep[$];
    int ed[$];

    vecs[0] = '{255, 127, 3, 3, 255, 127};
    vecs[1] = '{10,  1,   3, 3, 10,  1};
    vecs[2] = '{10,  9,   3, 3, 10,  9};
    vecs[3] = '{2,   1,   4, 4, 2,   1};
    vecs[4] = '{7,   3,   3, 3, 7,   3};

    // reset state
    reset = 1'b1; pwm_in = 1'b0; enable = 1'b1; clear_ovf = 1'b0;
    cyc = 0; ovf_cyc = -1;
    #1;
    check("rst_period", int'(period), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_overflow", int'(overflow), 0);

    // table-driven constant PWM patterns
    foreach (vecs[v]) begin
      do_reset(1'b0);
      idle_low(3);
      first = cyc + 1;
      for (int k = 0; k < vecs[v].nper; k++) pwm_period(vecs[v].per, vecs[v].dty);
      step(1'b1);
      idle_low(6);
      check($sformatf("v%0d_count", v), caps.size(), vecs[v].exp_count);
      foreach (caps[j]) begin
        check($sformatf("v%0d_per%0d", v, j), caps[j].per, vecs[v].exp_per);
        check($sformatf("v%0d_duty%0d", v, j), caps[j].dty, vecs[v].exp_duty);
        check($sformatf("v%0d_cyc%0d", v, j), caps[j].cyc, first + (j + 1) * vecs[v].per + LAT);
      end
      check($sformatf("v%0d_ovf", v), int'(overflow), 0);
    end

    // duty change at fixed period: valids stay 10 cycles apart
    do_reset(1'b0);
    idle_low(3);
    first = cyc + 1;
    pwm_period(10, 1); pwm_period(10, 1);
    pwm_period(10, 9); pwm_period(10, 9);
    step(1'b1);
    idle_low(6);
    ep = '{10, 10, 10, 10};
    ed = '{1, 1, 9, 9};
    check_caps("dchg", first + 10 + LAT, ep, ed);
    foreach (caps[j]) if (j > 0) check($sformatf("dchg_gap%0d", j), caps[j].cyc - caps[j-1].cyc, 10);

    // asynchronous reset mid-measurement discards the period
    do_reset(1'b0);
    idle_low(3);
    pwm_period(10, 3);
    pwm_period(10, 3);
    step(1'b1); step(1'b1); step(1'b0);
    reset = 1'b1;
    #2;
    check("amid_period", int'(period), 0);
    check("amid_valid", int'(valid), 0);
    check("amid_state", int'(dut.state), int'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    caps.delete();
    idle_low(15);
    check("amid_novalid", caps.size(), 0);

    // stuck-high line: overflow exactly 255 cycles after the rise
    do_reset(1'b0);
    idle_low(3);
    pwm_period(10, 3);
    c = cyc + 1;
    for (int i = 0; i < 300; i++) step(1'b1);
    check("ovf_cyc", ovf_cyc, c + 255 + LAT);
    check("ovf_caps", caps.size(), 1);
    check("ovf_state", int'(dut.state), int'(IDLE));
    check("ovf_hold_per", int'(period), 10);
    check("ovf_hold_duty", int'(duty), 3);
    check("ovf_sticky", int'(overflow), 1);
    clear_ovf = 1'b1;
    step(1'b1);
    clear_ovf = 1'b0;
    check("ovf_clear", int'(overflow), 0);
    step(1'b1);
    check("ovf_stay_clear", int'(overflow), 0);

    // clear coinciding with a fresh overflow: set wins
    idle_low(3);
    for (int i = 0; i < 255 + LAT; i++) step(1'b1);
    check("ovf_pre_set", int'(overflow), 0);
    clear_ovf = 1'b1;
    step(1'b1);
    clear_ovf = 1'b0;
    check("ovf_set_wins", int'(overflow), 1);

`ifndef PWM_CAPTURE_SYNC_EN
    // line high through reset release is not a rise
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1);
    idle_low(5);
    first = cyc + 1;
    for (int k = 0; k < 3; k++) pwm_period(10, 3);
    step(1'b1);
    idle_low(6);
    ep = '{10, 10, 10};
    ed = '{3, 3, 3};
    check_caps("rhigh", first + 10, ep, ed);
`endif

    // enable dropped for 3 cycles mid-period
    do_reset(1'b0);
    idle_low(3);
    c = cyc + 1;
    pwm_period(10, 4);
    for (int i = 0; i < 10; i++) begin
      enable = !(i >= 5 && i < 8);
      step(i < 4);
    end
    enable = 1'b1;
    pwm_period(10, 4);
    pwm_period(10, 4);
    step(1'b1);
    idle_low(6);
    ep = '{10, 10, 10};
    ed = '{4, 4, 4};
    check_caps("en", c + 10 + LAT, ep, ed);
    if (caps.size() == 3) begin
      check("en_cyc1", caps[1].cyc, c + 30 + LAT);
      check("en_cyc2", caps[2].cyc, c + 40 + LAT);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the period/duty counters and outputs.
REQ-002 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  capture enable; low forces IDLE.
REQ-005 SHALL have port pwm_in  input  1  PWM signal under measurement.
REQ-006 SHALL have port clear_ovf  input  1  synchronous clear of overflow.
REQ-007 SHALL have port period  output  WIDTH  last measured period, in clk cycles.
REQ-008 SHALL have port duty  output  WIDTH  last measured high-cycle count.
REQ-009 SHALL have port valid  output  1  one-cycle pulse when period/duty update.
REQ-010 SHALL have port overflow  output  1  sticky; period exceeded 2^WIDTH-1.

Function
REQ-011 SHALL define sampled level s = pwm_in (or its synchronized version, see Configuration), prev = s registered, and rise = s & ~prev.
REQ-012 SHALL implement FSM states IDLE and MEASURE.
REQ-013 IDLE: on rise with enable=1, SHALL go to MEASURE and load cnt_period=1, cnt_high=1; no valid.
REQ-014 MEASURE, non-rise cycle: SHALL increment cnt_period by 1 and cnt_high by s.
REQ-015 MEASURE, rise: SHALL register period<=cnt_period and duty<=cnt_high, pulse valid for exactly one cycle, reload both counters to 1, and stay in MEASURE.
REQ-016 valid SHALL assert on the cycle after the edge at which rise is sampled; period/duty SHALL be stable from valid until the next valid.
REQ-017 MEASURE, no rise, cnt_period == 2^WIDTH-1: SHALL set overflow, go to IDLE, suppress valid, and leave period/duty unchanged (timeout covers 0% and 100% duty).
REQ-018 Measurable periods SHALL be 2..2^WIDTH-1; duty SHALL always satisfy 1 <= duty <= period-1 when valid.
REQ-019 enable=0 SHALL force IDLE next cycle and hold counters, with no valid; re-enable SHALL wait for the next rise, and the partial period is discarded.
REQ-020 clear_ovf SHALL clear overflow next cycle; if it coincides with a new overflow event, set SHALL win.
REQ-021 Counters SHALL saturate, never wrap.

Reset
REQ-022 Reset SHALL asynchronously force state=IDLE, counters=0, period=0, duty=0, valid=0, overflow=0, synchronizer flops=0, and prev=1, so a line already high at reset release is not a rise.
REQ-023 Reset asserted mid-measurement SHALL discard the partial period with no valid.

Configuration
REQ-024 Macro PWM_CAPTURE_SYNC_EN defined: pwm_in SHALL pass through a two-flop synchronizer before s, adding exactly 2 cycles to valid latency; measured values SHALL be unchanged.
REQ-025 Macro undefined: s SHALL be pwm_in directly, and pwm_in is assumed synchronous to clk.

Structure
REQ-026 Package pwm_pkg SHALL hold typedef enum pwm_cap_state_t {IDLE, MEASURE} and constant PWM_DEFAULT_WIDTH=8.
REQ-027 Sub-module pwm_edge_detect SHALL contain the optional synchronizer, the prev flop, and the rise output; the FSM and counters SHALL reside in pwm_capture.

Verification
REQ-028 ConstantPWM PERIOD=255 DUTY=127, enable=1 -> from the second rise on, every valid shows period=255, duty=127, with no overflow.
REQ-029 PERIOD=10 DUTY=1, then DUTY=9 -> valid shows (10,1), then (10,9); valid is spaced exactly 10 cycles apart.
REQ-030 pwm_in held high 300 cycles after one rise, WIDTH=8 -> overflow=1 exactly 255 cycles after the rise, no valid, state IDLE; clear_ovf pulse -> overflow=0.
REQ-031 pwm_in high during reset release -> no valid until the second subsequent rise; first capture is correct.
REQ-032 enable dropped for 3 cycles mid-period -> no valid for that period; the next full period is measured correctly.
REQ-033 Repeat REQ-028 with PWM_CAPTURE_SYNC_EN defined -> identical values, valid 2 cycles later.
